abs_tracked_memory: RTL

ABS_TRACKED_MEMORY -- requirements
Module: abs_tracked_memory

---
 rtl/abs_mem_pkg.sv | 25 ++
 rtl/abs_mem_slot.sv | 50 +++++
 rtl/abs_tracked_memory.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/abs_mem_pkg.sv
// ============================================================================
// abs_mem_pkg : default parameters and width helpers for abs_tracked_memory
// Revision    : 1.0
// ============================================================================
`default_nettype none

package abs_mem_pkg;

  localparam int DEF_ASIZE  = 8;
  localparam int DEF_DSIZE  = 8;
  localparam int DEF_NSLOTS = 4;
  localparam int DEF_RD_REG = 0;

  // A single slot still needs a one-bit index so the victim pointer has a legal type.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int occ_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/abs_mem_slot.sv
// ============================================================================
// abs_mem_slot : one tracked entry (valid/tag/data) with its tag comparator
// Revision     : 1.0
// ============================================================================
`default_nettype none

module abs_mem_slot
  import abs_mem_pkg::*;
#(
  parameter int ASIZE = DEF_ASIZE,
  parameter int DSIZE = DEF_DSIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [ASIZE-1:0] load_tag,
  input  logic [DSIZE-1:0] load_data,
  input  logic [ASIZE-1:0] cmp_addr,
  output logic             valid,
  output logic [DSIZE-1:0] data,
  output logic             match
);

  logic             r_valid;
  logic [ASIZE-1:0] r_tag;
  logic [DSIZE-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (load) begin
      r_valid <= 1'b1;
    end
  end

  // Tag and data are deliberately left out of reset; valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (load) begin
      r_tag  <= load_tag;
      r_data <= load_data;
    end
  end

  assign valid = r_valid;
  assign data  = r_data;
  assign match = r_valid && (r_tag == cmp_addr);

endmodule

`default_nettype wire

// File: rtl/abs_tracked_memory.sv
// ============================================================================
// abs_tracked_memory : abstract memory tracking NSLOTS addresses, free data elsewhere
// Revision           : 1.0
// ============================================================================
`default_nettype none

module abs_tracked_memory
  import abs_mem_pkg::*;
#(
  parameter int ASIZE  = DEF_ASIZE,
  parameter int DSIZE  = DEF_DSIZE,
  parameter int NSLOTS = DEF_NSLOTS,
  parameter int RD_REG = DEF_RD_REG
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            we,
  input  logic [ASIZE-1:0]                addr,
  input  logic [DSIZE-1:0]                mem_in,
  input  logic [DSIZE-1:0]                free_data,
  output logic [DSIZE-1:0]                mem_out,
  output logic                            hit,
  output logic                            evict,
  output logic [occ_width(NSLOTS)-1:0]    occupancy,
  output logic                            full
);

  localparam int IW = idx_width(NSLOTS);
  localparam int OW = occ_width(NSLOTS);
  localparam logic [OW-1:0] C_NSLOTS_OCC = OW'(NSLOTS);
  localparam logic [IW-1:0] C_LAST_IDX   = IW'(NSLOTS - 1);

  logic [NSLOTS-1:0] w_valid;
  logic [NSLOTS-1:0] w_match;
  logic [NSLOTS-1:0] w_load;
  logic [DSIZE-1:0]  w_slot_data [NSLOTS];

  logic [IW-1:0]     w_free_idx;
  logic [DSIZE-1:0]  w_rdata;
  logic              w_hit;
  logic              w_wr;
  logic              w_alloc;
  logic              w_replace;
  logic [OW-1:0]     w_occ_inc;

  logic [OW-1:0]     r_occ;
  logic              r_full;
  logic              r_evict;
  logic [IW-1:0]     r_victim;

  generate
    for (genvar gi = 0; gi < NSLOTS; gi++) begin : g_slot
      abs_mem_slot #(
        .ASIZE (ASIZE),
        .DSIZE (DSIZE)
      ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load[gi]),
        .load_tag  (addr),
        .load_data (mem_in),
        .cmp_addr  (addr),
        .valid     (w_valid[gi]),
        .data      (w_slot_data[gi]),
        .match     (w_match[gi])
      );
    end
  endgenerate

  // Lowest-index invalid slot; scanning downward lets the lowest index win.
  always_comb begin
    w_free_idx = '0;
    for (int i = NSLOTS - 1; i >= 0; i--) begin
      if (!w_valid[i]) begin
        w_free_idx = IW'(i);
      end
    end
  end

  // Tags are unique, so at most one match bit is set and an OR-reduce is exact.
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NSLOTS; i++) begin
      w_rdata = w_rdata | (w_slot_data[i] & {DSIZE{w_match[i]}});
    end
  end

  assign w_hit     = |w_match;
  assign w_wr      = we && !rst;
  assign w_alloc   = w_wr && !w_hit && !r_full;
  assign w_replace = w_wr && !w_hit && r_full;
  assign w_occ_inc = r_occ + OW'(1);

  always_comb begin
    w_load = '0;
    for (int i = 0; i < NSLOTS; i++) begin
      if (w_wr) begin
        if (w_hit) begin
          w_load[i] = w_match[i];
        end else if (!r_full) begin
          w_load[i] = (IW'(i) == w_free_idx);
        end else begin
          w_load[i] = (IW'(i) == r_victim);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ    <= '0;
      r_full   <= 1'b0;
      r_evict  <= 1'b0;
      r_victim <= '0;
    end else begin
      r_evict <= w_replace;
      if (w_alloc) begin
        r_occ  <= w_occ_inc;
        r_full <= (w_occ_inc == C_NSLOTS_OCC);
      end
      if (w_replace) begin
        r_victim <= (r_victim == C_LAST_IDX) ? '0 : r_victim + IW'(1);
      end
    end
  end

  assign occupancy = r_occ;
  assign full      = r_full;
  assign evict     = r_evict;

  generate
    if (RD_REG != 0) begin : g_rd_reg
      logic [DSIZE-1:0] r_mem_out;
      logic             r_hit;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_mem_out <= '0;
          r_hit     <= 1'b0;
        end else begin
          r_mem_out <= w_hit ? w_rdata : free_data;
          r_hit     <= w_hit;
        end
      end

      assign mem_out = r_mem_out;
      assign hit     = r_hit;
    end else begin : g_rd_comb
      assign mem_out = w_hit ? w_rdata : free_data;
      assign hit     = w_hit;
    end
  endgenerate

endmodule

`default_nettype wire
